// File: rtl/grey_statis_acc.sv
// grey_statis_acc
// Grey-statistics accumulator and result holder. Sums and counts pixels while
// the AOI frame and line valids are high, captures the totals at frame end and
// presents them on the output ports on a rising edge of the interrupt pin. The
// firmware therefore always reads a sum/count pair that belongs to one frame.

module grey_statis_acc #(
  parameter int SENSOR_DAT_WIDTH  = 10,
  parameter int GREY_OFFSET_WIDTH = 12,
  parameter int GREY_STATIS_WIDTH = 48
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_fval,
  input  logic                           i_lval,
  input  logic [SENSOR_DAT_WIDTH-1:0]    iv_pix_data,
  input  logic                           i_interrupt_en,
  input  logic                           i_interrupt_pin,
  output logic [GREY_STATIS_WIDTH-1:0]   ov_grey_statis_sum,
  output logic [2*GREY_OFFSET_WIDTH-1:0] ov_grey_pix_cnt,
  output logic                           o_statis_overflow,
  output logic                           o_statis_done
);

  localparam int CNT_W = 2 * GREY_OFFSET_WIDTH;
  localparam int PAD_W = GREY_STATIS_WIDTH - SENSOR_DAT_WIDTH;

  // WAIT_LOW keeps a frame that was already running at reset release out of
  // the statistics; only frames whose rising edge we actually see are summed.
  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ACC      = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     fval_dly_q, fval_dly_d;
  logic                     int_dly_q, int_dly_d;

  logic [GREY_STATIS_WIDTH-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0]             acc_cnt_q, acc_cnt_d;
  logic                         acc_ovf_q, acc_ovf_d;

  logic [GREY_STATIS_WIDTH-1:0] frame_sum_q, frame_sum_d;
  logic [CNT_W-1:0]             frame_cnt_q, frame_cnt_d;
  logic                         frame_ovf_q, frame_ovf_d;
  logic                         frame_valid_q, frame_valid_d;

  logic [GREY_STATIS_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]             out_cnt_q, out_cnt_d;
  logic                         out_ovf_q, out_ovf_d;
  logic                         done_q, done_d;

  logic                         fval_rise_s;
  logic                         fval_fall_s;
  logic                         int_rise_s;
  logic                         frame_end_s;
  logic                         pix_take_s;
  logic [GREY_STATIS_WIDTH-1:0] pix_ext_s;
  logic [GREY_STATIS_WIDTH:0]   sum_add_s;
  logic                         cnt_full_s;

  // Edge detection on frame valid and interrupt pin, plus datapath helpers.
  always_comb begin
    fval_dly_d  = i_fval;
    int_dly_d   = i_interrupt_pin;
    fval_rise_s = i_fval & ~fval_dly_q;
    fval_fall_s = ~i_fval & fval_dly_q;
    int_rise_s  = i_interrupt_pin & ~int_dly_q;
    frame_end_s = (state_q == ACC) & fval_fall_s;
    pix_take_s  = i_fval & i_lval;
    pix_ext_s   = {{PAD_W{1'b0}}, iv_pix_data};
    sum_add_s   = {1'b0, acc_sum_q} + {1'b0, pix_ext_s};
    cnt_full_s  = &acc_cnt_q;
  end

  // State register and all other flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOW;
      fval_dly_q    <= 1'b0;
      int_dly_q     <= 1'b0;
      acc_sum_q     <= {GREY_STATIS_WIDTH{1'b0}};
      acc_cnt_q     <= {CNT_W{1'b0}};
      acc_ovf_q     <= 1'b0;
      frame_sum_q   <= {GREY_STATIS_WIDTH{1'b0}};
      frame_cnt_q   <= {CNT_W{1'b0}};
      frame_ovf_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      out_sum_q     <= {GREY_STATIS_WIDTH{1'b0}};
      out_cnt_q     <= {CNT_W{1'b0}};
      out_ovf_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fval_dly_q    <= fval_dly_d;
      int_dly_q     <= int_dly_d;
      acc_sum_q     <= acc_sum_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_ovf_q     <= acc_ovf_d;
      frame_sum_q   <= frame_sum_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_ovf_q   <= frame_ovf_d;
      frame_valid_q <= frame_valid_d;
      out_sum_q     <= out_sum_d;
      out_cnt_q     <= out_cnt_d;
      out_ovf_q     <= out_ovf_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic of the frame tracker.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOW: begin
        if (!i_fval) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LOW;
        end
      end
      IDLE: begin
        if (fval_rise_s) begin
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (fval_fall_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
  end

  // Accumulator and per-frame capture; the rise edge restarts the sums with
  // the pixel present on that edge so the first pixel of a frame is not lost.
  always_comb begin
    acc_sum_d   = acc_sum_q;
    acc_cnt_d   = acc_cnt_q;
    acc_ovf_d   = acc_ovf_q;
    frame_sum_d = frame_sum_q;
    frame_cnt_d = frame_cnt_q;
    frame_ovf_d = frame_ovf_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fval_rise_s) begin
          if (i_lval) begin
            acc_sum_d = pix_ext_s;
          end else begin
            acc_sum_d = {GREY_STATIS_WIDTH{1'b0}};
          end
          acc_cnt_d = {{(CNT_W-1){1'b0}}, i_lval};
          acc_ovf_d = 1'b0;
        end else begin
          acc_ovf_d = acc_ovf_q;
        end
      end
      ACC: begin
        if (fval_fall_s) begin
          frame_sum_d = acc_sum_q;
          frame_cnt_d = acc_cnt_q;
          frame_ovf_d = acc_ovf_q;
          done_d      = 1'b1;
        end else if (pix_take_s) begin
          if (sum_add_s[GREY_STATIS_WIDTH]) begin
            acc_sum_d = {GREY_STATIS_WIDTH{1'b1}};
            acc_ovf_d = 1'b1;
          end else begin
            acc_sum_d = sum_add_s[GREY_STATIS_WIDTH-1:0];
          end
          if (cnt_full_s) begin
            acc_cnt_d = acc_cnt_q;
          end else begin
            acc_cnt_d = acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Result hand-off to the ports; a pin rise always publishes the pre-edge
  // frame results, even when a new frame ends on the same edge.
  always_comb begin
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    if (int_rise_s && frame_valid_q) begin
      out_sum_d = frame_sum_q;
      out_cnt_d = frame_cnt_q;
      out_ovf_d = frame_ovf_q;
    end else begin
      out_ovf_d = out_ovf_q;
    end

    if (frame_end_s) begin
      frame_valid_d = i_interrupt_en;
    end else if (int_rise_s && frame_valid_q) begin
      frame_valid_d = 1'b0;
    end else if (!i_interrupt_en) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
  end

  assign ov_grey_statis_sum = out_sum_q;
  assign ov_grey_pix_cnt    = out_cnt_q;
  assign o_statis_overflow  = out_ovf_q;
  assign o_statis_done      = done_q;

endmodule

// File: tb/tb_grey_statis_acc.sv
// Directed bench for grey_statis_acc: one instance with default widths and one
// narrow instance (12-bit sum, 2-bit count) to reach saturation.

module tb_grey_statis_acc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fval;
  logic       lval;
  logic       en;
  logic       pin;
  logic [9:0] pix;

  logic [47:0] a_sum;
  logic [23:0] a_cnt;
  logic        a_ovf;
  logic        a_done;
  logic [11:0] b_sum;
  logic [1:0]  b_cnt;
  logic        b_ovf;
  logic        b_done;

  int total = 0;
  int bad   = 0;
  int a_done_n = 0;
  int b_done_n = 0;
  int d0;

  always #5 clk = ~clk;

  grey_statis_acc u_dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_fval             (fval),
    .i_lval             (lval),
    .iv_pix_data        (pix),
    .i_interrupt_en     (en),
    .i_interrupt_pin    (pin),
    .ov_grey_statis_sum (a_sum),
    .ov_grey_pix_cnt    (a_cnt),
    .o_statis_overflow  (a_ovf),
    .o_statis_done      (a_done)
  );

  grey_statis_acc #(
    .SENSOR_DAT_WIDTH  (10),
    .GREY_OFFSET_WIDTH (1),
    .GREY_STATIS_WIDTH (12)
  ) u_dut_narrow (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_fval             (fval),
    .i_lval             (lval),
    .iv_pix_data        (pix),
    .i_interrupt_en     (en),
    .i_interrupt_pin    (pin),
    .ov_grey_statis_sum (b_sum),
    .ov_grey_pix_cnt    (b_cnt),
    .o_statis_overflow  (b_ovf),
    .o_statis_done      (b_done)
  );

  // count done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (a_done) a_done_n++;
    if (b_done) b_done_n++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic l, input logic [9:0] d);
    fval = f;
    lval = l;
    pix  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int nl, input int npl, input logic [9:0] d, input logic pin_on_fall);
    cyc(1'b1, 1'b0, 10'd0);
    for (int ln = 0; ln < nl; ln++) begin
      for (int px = 0; px < npl; px++) cyc(1'b1, 1'b1, d);
      cyc(1'b1, 1'b0, 10'd0);
      cyc(1'b1, 1'b0, 10'd0);
    end
    if (pin_on_fall) pin = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd0);
  endtask

  task automatic pin_rise();
    pin = 1'b0;
    cyc(1'b0, 1'b0, 10'd0);
    pin = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    pin = 1'b0;
    cyc(1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    fval = 1'b0; lval = 1'b0; pix = 10'd0; en = 1'b1; pin = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 10'd0);
    check("rst_sum",  a_sum,  0);
    check("rst_cnt",  a_cnt,  0);
    check("rst_ovf",  a_ovf,  0);
    check("rst_done", a_done, 0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd0);

    // 4x8 frame of 5
    d0 = a_done_n;
    frame(4, 8, 10'd5, 1'b0);
    check("done_once", a_done_n - d0, 1);
    check("prelatch_sum", a_sum, 0);
    pin_rise();
    check("f1_sum", a_sum, 160);
    check("f1_cnt", a_cnt, 32);
    check("f1_ovf", a_ovf, 0);

    // pin rise without a new frame
    pin_rise();
    check("nofr_sum", a_sum, 160);
    check("nofr_cnt", a_cnt, 32);

    // frame ended with en low is not published
    en = 1'b0;
    frame(2, 4, 10'd9, 1'b0);
    en = 1'b1;
    pin_rise();
    check("en0_sum", a_sum, 160);
    check("en0_cnt", a_cnt, 32);

    // pin held high: no latch until a fresh rise
    pin = 1'b1;
    cyc(1'b0, 1'b0, 10'd0);
    frame(1, 4, 10'd2, 1'b0);
    check("held_sum", a_sum, 160);
    pin_rise();
    check("held2_sum", a_sum, 8);
    check("held2_cnt", a_cnt, 4);

    // fall and pin rise on the same edge
    d0 = a_done_n;
    frame(4, 8, 10'd5, 1'b0);
    frame(2, 8, 10'd4, 1'b1);
    check("simul_sum", a_sum, 160);
    check("simul_cnt", a_cnt, 32);
    pin_rise();
    check("simul2_sum", a_sum, 64);
    check("simul2_cnt", a_cnt, 16);
    check("simul_done", a_done_n - d0, 2);

    // reset mid-frame, released with fval high
    d0 = a_done_n;
    cyc(1'b1, 1'b0, 10'd0);
    repeat (3) cyc(1'b1, 1'b1, 10'd7);
    reset_n = 1'b0;
    #1;
    check("midrst_sum", a_sum, 0);
    check("midrst_cnt", a_cnt, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b1, 10'd7);
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd0);
    check("midrst_nodone", a_done_n - d0, 0);
    pin_rise();
    check("midrst_pin_sum", a_sum, 0);
    check("midrst_pin_cnt", a_cnt, 0);
    frame(4, 8, 10'd3, 1'b0);
    pin_rise();
    check("after_rst_sum", a_sum, 96);
    check("after_rst_cnt", a_cnt, 32);

    // back-to-back frames, first pixel on the rise edge
    d0 = a_done_n;
    repeat (6) cyc(1'b1, 1'b1, 10'd7);
    cyc(1'b0, 1'b0, 10'd0);
    repeat (4) cyc(1'b1, 1'b1, 10'd2);
    pin = 1'b1;
    cyc(1'b1, 1'b1, 10'd2);
    check("b2b_a_sum", a_sum, 42);
    check("b2b_a_cnt", a_cnt, 6);
    repeat (5) cyc(1'b1, 1'b1, 10'd2);
    cyc(1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b0, 10'd0);
    pin_rise();
    check("b2b_b_sum", a_sum, 20);
    check("b2b_b_cnt", a_cnt, 10);
    check("b2b_done", a_done_n - d0, 2);

    // saturation on the narrow instance
    d0 = b_done_n;
    frame(1, 8, 10'd1023, 1'b0);
    pin_rise();
    check("sat_sum", b_sum, 4095);
    check("sat_ovf", b_ovf, 1);
    check("sat_cnt", b_cnt, 3);
    check("sat_done", b_done_n - d0, 1);
    check("wide_sum", a_sum, 8184);
    check("wide_cnt", a_cnt, 8);
    check("wide_ovf", a_ovf, 0);
    frame(1, 2, 10'd1, 1'b0);
    pin_rise();
    check("unsat_sum", b_sum, 2);
    check("unsat_ovf", b_ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grey_statis_acc.md
# grey_statis_acc

Grey-statistics accumulator and result holder, the consumer of the AOI-gated pixel stream in the grey statistics path. Sums pixel values and counts pixels while AOI frame/line valid are high, and captures per-frame results at frame end. Presents the captured results on its ports on the rising edge of the interrupt pin, so firmware reads a stable sum/count pair for the same frame as the window registers.

## Interface
- SENSOR_DAT_WIDTH, 10, pixel data width
- GREY_OFFSET_WIDTH, 12, window register width; pixel count width is 2*GREY_OFFSET_WIDTH
- GREY_STATIS_WIDTH, 48, sum width; must be ≥ SENSOR_DAT_WIDTH + 2*GREY_OFFSET_WIDTH
- clk  in  1  pixel clock; sole clock
- reset_n  in  1  asynchronous, active-low reset
- i_fval  in  1  AOI frame valid, from AOI selector
- i_lval  in  1  AOI line valid; high only inside the statistics window
- iv_pix_data  in  SENSOR_DAT_WIDTH  pixel data, aligned with i_lval
- i_interrupt_en  in  1  statistics-valid flag from AOI selector
- i_interrupt_pin  in  1  interrupt line; rising edge latches results to ports
- ov_grey_statis_sum  out  GREY_STATIS_WIDTH  latched pixel sum
- ov_grey_pix_cnt  out  2*GREY_OFFSET_WIDTH  latched pixel count
- o_statis_overflow  out  1  latched: sum saturated in that frame
- o_statis_done  out  1  one-cycle pulse per completed frame

## Operation
- Registered fval_dly tracks i_fval. Rise = i_fval & !fval_dly; fall = !i_fval & fval_dly. Registered int_dly tracks i_interrupt_pin; int rise = pin & !int_dly.
- State machine, reset state WAIT_LOW:
  - WAIT_LOW: go to IDLE when i_fval sampled 0. A frame already in progress at reset release is never accumulated.
  - IDLE: on rise, go to ACC. At that edge acc_sum <= (i_lval ? iv_pix_data : 0); acc_cnt <= i_lval; acc_ovf <= 0.
  - ACC: each edge with i_fval=1 and i_lval=1, acc_sum += iv_pix_data, acc_cnt += 1. On fall, go to IDLE; frame_sum/frame_cnt/frame_ovf <= acc values; done pulse; frame_valid <= i_interrupt_en.
- Pixels with i_lval=1 and i_fval=0 are ignored.
- Saturation: if acc_sum + pixel exceeds all-ones, acc_sum holds all-ones and acc_ovf <= 1. acc_cnt saturates at all-ones, with no flag.
- i_interrupt_en low at any edge clears frame_valid. Accumulation still runs.
- Result latch: on int rise with frame_valid=1, ports <= frame_sum/frame_cnt/frame_ovf and frame_valid <= 0. Int rise with frame_valid=0 leaves ports unchanged.
- Simultaneous fall and int rise: ports take the pre-edge frame_* values if frame_valid was 1. The new frame's results load into frame_*, and frame_valid <= i_interrupt_en.
- Reset asserted mid-frame: all state clears immediately and the FSM returns to WAIT_LOW.

## Timing
- Reset values: all outputs 0; acc/frame registers 0; frame_valid 0; fval_dly and int_dly 0; state WAIT_LOW.
- Sum latency: a pixel sampled at edge N is in acc_sum after edge N.
- o_statis_done is high in the cycle after the fall edge, for exactly one cycle. frame_* are valid in that same cycle.
- Port update is visible in the cycle after the int-rise edge. A pin held high causes no further latches.
- Back-to-back frames: fval low for a single cycle is legal. Fall and the next rise are distinct edges, and no pixels are lost.

## Test plan
- Frame of 4 lines × 8 pixels, data = 5, en=1, then pin rise → done pulse once; after the pin edge, sum=160, cnt=32, ovf=0.
- Pin rise with no completed frame since the last latch, and pin rise on a frame ended with en=0 → ports unchanged from prior values (for example 160/32).
- GREY_STATIS_WIDTH=12, 8 pixels of 1023 → sum=4095, ovf=1 after latch.
- Fall and pin rise on the same edge, previous frame 160/32, new frame 64/16 → ports 160/32. Second pin rise → 64/16.
- reset_n pulsed low mid-frame, released with fval high → outputs 0, no done pulse for that frame. The next full frame accumulates correctly.
- Two frames separated by one-cycle fval low, first pixel on the rise edge → both counts exact, including the first pixel.
